// File: rtl/aileron_pkg.sv
// Shared types and constants for the aileron ramp sequencer.
// Angles are 4-bit two's complement; the code 4'b1000 is never a legal surface position.
package aileron_pkg;

   typedef logic signed [3:0] angle_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   localparam angle_t     ANG_MIN     = -4'sd7;
   localparam angle_t     ANG_MAX     = 4'sd7;
   localparam logic [3:0] ANG_ILLEGAL = 4'b1000;

   // The single illegal code folds onto the nearest legal extreme.
   function automatic angle_t clamp_angle(input logic [3:0] raw);
      if (raw == ANG_ILLEGAL) begin
         return ANG_MIN;
      end
      return angle_t'(raw);
   endfunction

endpackage

// File: rtl/aileron_ramp_ctrl_if.sv
// Command and status bundle between the flight-control source and the ramp sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready; the source holds
// cmd_valid/cmd_angle stable until then, and cmd_ready never depends on cmd_valid.
interface aileron_ramp_ctrl_if;
   import aileron_pkg::*;

   logic       cmd_valid;
   logic [3:0] cmd_angle;
   logic       cmd_ready;
   logic       center_req;
   angle_t     angulacao;
   logic       busy;
   logic       done;
   logic       err_clamp;
   state_t     dbg_state;

   modport master (
      output cmd_valid, cmd_angle, center_req,
      input  cmd_ready, angulacao, busy, done, err_clamp, dbg_state
   );

   modport slave (
      input  cmd_valid, cmd_angle, center_req,
      output cmd_ready, angulacao, busy, done, err_clamp, dbg_state
   );

endinterface

// File: rtl/aileron_step_timer.sv
// Reloadable down-counter shared by the step and settle phases.
// Load beats hold; otherwise it counts down and parks at zero.
module aileron_step_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         hold,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (!hold && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/aileron_ramp_ctrl.sv
// Slew-rate-limited aileron angle sequencer: ramps the registered angle one count every
// STEP_CYCLES clocks toward the commanded target, settles, then pulses done.
module aileron_ramp_ctrl
   import aileron_pkg::*;
#(
   parameter int STEP_CYCLES   = 4,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   aileron_ramp_ctrl_if.slave  bus
);

   localparam int MAX_CYC = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t state_q, state_d;
   angle_t angle_q, angle_d;
   angle_t target_q, target_d;
   logic   done_q, done_d;
   logic   err_q, err_d;

   logic             tmr_load;
   logic             tmr_hold;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             cmd_ready_w;
   logic             accept;
   logic             center_hit;

   aileron_step_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .hold     (tmr_hold),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         angle_q  <= '0;
         target_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         angle_q  <= angle_d;
         target_q <= target_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      angle_d    = angle_q;
      target_d   = target_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      tmr_load   = 1'b0;
      tmr_hold   = 1'b0;
      tmr_val    = STEP_LOAD;
      accept     = bus.cmd_valid && cmd_ready_w;
      center_hit = bus.center_req && (target_q != '0);

      if (center_hit) begin
         target_d = '0;
      end

      case (state_q)
         IDLE: begin
            tmr_hold = 1'b1;
            if (center_hit) begin
               state_d  = MOVE;
               tmr_load = 1'b1;
            end else if (accept) begin
               target_d = clamp_angle(bus.cmd_angle);
               err_d    = (bus.cmd_angle == ANG_ILLEGAL);
               if (target_d == angle_q) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = MOVE;
                  tmr_load = 1'b1;
               end
            end
         end

         // A centre request arriving here only retargets; step timing is left untouched.
         MOVE: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if ((target_d > angle_q) && (angle_q != ANG_MAX)) begin
                  angle_d = angle_q + 4'sd1;
               end else if ((target_d < angle_q) && (angle_q != ANG_MIN)) begin
                  angle_d = angle_q - 4'sd1;
               end
               if (angle_d == target_d) begin
                  state_d = SETTLE;
                  tmr_val = SETTLE_LOAD;
               end
            end
         end

         SETTLE: begin
            if (center_hit) begin
               state_d  = MOVE;
               tmr_load = 1'b1;
            end else if (tmr_zero) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               tmr_hold = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cmd_ready_w   = (state_q == IDLE) && !bus.center_req && rst_n;
      bus.cmd_ready = cmd_ready_w;
      bus.angulacao = angle_q;
      bus.busy      = (state_q != IDLE);
      bus.done      = done_q;
      bus.err_clamp = err_q;
      bus.dbg_state = state_q;
   end

endmodule

// File: tb/tb_aileron_ramp_ctrl.sv
// Self-checking bench for aileron_ramp_ctrl: directed scenarios plus a randomized run,
// all compared against a timestamp-based reference model of the ramp rules.
module tb_aileron_ramp_ctrl;
  import aileron_pkg::*;

  localparam int STEP   = 4;
  localparam int SETTLE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aileron_ramp_ctrl_if bus();

  aileron_ramp_ctrl #(
    .STEP_CYCLES   (STEP),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model: phase 0 = idle, 1 = ramping, 2 = settling; events kept as absolute edge numbers.
  int m_angle  = 0;
  int m_target = 0;
  int m_phase  = 0;
  int m_next   = 0;
  int m_settle = 0;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] obs;
  assign obs = {bus.angulacao, bus.busy, bus.done, bus.err_clamp, bus.cmd_ready};

  function automatic logic [7:0] model_vec();
    logic [3:0] a;
    a = 4'(m_angle);
    return {a, (m_phase != 0), m_done, m_err, ((m_phase == 0) && !bus.center_req && rst_n)};
  endfunction

  // Advance the model by the edge about to happen, then clock the DUT and settle.
  task automatic step();
    int t;
    bit was_ramp;
    bit was_settle;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!rst_n) begin
      m_angle  = 0;
      m_target = 0;
      m_phase  = 0;
    end else begin
      was_ramp   = (m_phase == 1);
      was_settle = (m_phase == 2);
      if (bus.center_req && (m_target != 0)) begin
        m_target = 0;
        if (!was_ramp) begin
          m_phase = 1;
          m_next  = cyc + STEP;
        end
      end else if ((m_phase == 0) && bus.cmd_valid && !bus.center_req) begin
        t = int'($signed(bus.cmd_angle));
        if (bus.cmd_angle == 4'b1000) begin
          t     = -7;
          m_err = 1'b1;
        end
        m_target = t;
        if (t == m_angle) begin
          m_done = 1'b1;
        end else begin
          m_phase = 1;
          m_next  = cyc + STEP;
        end
      end
      if (was_ramp && (cyc == m_next)) begin
        if (m_angle != m_target) m_angle += (m_target > m_angle) ? 1 : -1;
        m_next = cyc + STEP;
        if (m_angle == m_target) begin
          m_phase  = 2;
          m_settle = cyc + SETTLE;
        end
      end else if (was_settle && (m_phase == 2) && (cyc == m_settle)) begin
        m_phase = 0;
        m_done  = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    bus.cmd_valid  = 1'b0;
    bus.center_req = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.cmd_valid  = 1'b0;
    bus.cmd_angle  = 4'd0;
    bus.center_req = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (obs !== 8'b0000_0001) begin
      tests_failed++;
      $display("FAIL reset_const got=%b exp=%b", obs, 8'b0000_0001);
    end
    tests_run++;
    if (obs !== model_vec()) begin
      tests_failed++;
      $display("FAIL reset_model got=%b exp=%b", obs, model_vec());
    end
  endtask

  task automatic test_ramp_up();
    int done_at = -1;
    bus.cmd_angle = 4'd3;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      tests_run++;
      if (obs !== model_vec()) begin
        tests_failed++;
        $display("FAIL ramp_up T%0d got=%b exp=%b", k, obs, model_vec());
      end
      if (bus.done && (done_at < 0)) done_at = k;
      if (k == 12) begin
        tests_run++;
        if (bus.angulacao !== 4'sd3) begin
          tests_failed++;
          $display("FAIL ramp_up_angle_T12 got=%0d exp=3", bus.angulacao);
        end
      end
    end
    tests_run++;
    if (done_at !== 15) begin
      tests_failed++;
      $display("FAIL ramp_up_done_latency got=%0d exp=15", done_at);
    end
  endtask

  task automatic test_ramp_down();
    int done_at = -1;
    bus.cmd_angle = 4'b1110;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      step();
      tests_run++;
      if (obs !== model_vec()) begin
        tests_failed++;
        $display("FAIL ramp_down T%0d got=%b exp=%b", k, obs, model_vec());
      end
      if (bus.done && (done_at < 0)) done_at = k;
      if (k == 20) begin
        tests_run++;
        if (bus.angulacao !== -4'sd2) begin
          tests_failed++;
          $display("FAIL ramp_down_angle_T20 got=%0d exp=-2", bus.angulacao);
        end
      end
    end
    tests_run++;
    if (done_at !== 23) begin
      tests_failed++;
      $display("FAIL ramp_down_done_latency got=%0d exp=23", done_at);
    end
  endtask

  task automatic test_center();
    int done_at = -1;
    do_reset();
    bus.cmd_angle = 4'd5;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 9) begin
        bus.center_req = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_angle  = 4'd7;
      end
      if (k == 21) begin
        bus.center_req = 1'b0;
        bus.cmd_valid  = 1'b0;
      end
      step();
      tests_run++;
      if (obs !== model_vec()) begin
        tests_failed++;
        $display("FAIL center T%0d got=%b exp=%b", k, obs, model_vec());
      end
      if (bus.done && (done_at < 0)) done_at = k;
      if ((k == 12) || (k == 16)) begin
        tests_run++;
        if (bus.angulacao !== ((k == 12) ? 4'sd1 : 4'sd0)) begin
          tests_failed++;
          $display("FAIL center_angle_T%0d got=%0d exp=%0d", k, bus.angulacao, (k == 12) ? 1 : 0);
        end
      end
    end
    tests_run++;
    if (done_at !== 19) begin
      tests_failed++;
      $display("FAIL center_done_latency got=%0d exp=19", done_at);
    end
  endtask

  task automatic test_clamp();
    int done_at = -1;
    do_reset();
    bus.cmd_angle = 4'b1000;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    tests_run++;
    if ((bus.err_clamp !== 1'b1) || (obs !== model_vec())) begin
      tests_failed++;
      $display("FAIL clamp_err got=%b exp=%b", obs, model_vec());
    end
    for (int k = 1; k <= 33; k++) begin
      step();
      tests_run++;
      if (obs !== model_vec()) begin
        tests_failed++;
        $display("FAIL clamp T%0d got=%b exp=%b", k, obs, model_vec());
      end
      if (bus.done && (done_at < 0)) done_at = k;
      if (k == 28) begin
        tests_run++;
        if (bus.angulacao !== -4'sd7) begin
          tests_failed++;
          $display("FAIL clamp_angle_T28 got=%0d exp=-7", bus.angulacao);
        end
      end
    end
    tests_run++;
    if (done_at !== 31) begin
      tests_failed++;
      $display("FAIL clamp_done_latency got=%0d exp=31", done_at);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.cmd_angle = 4'd4;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests_run++;
      if (obs !== model_vec()) begin
        tests_failed++;
        $display("FAIL reset_mid T%0d got=%b exp=%b", k, obs, model_vec());
      end
    end
    rst_n = 1'b0;
    step();
    tests_run++;
    if ((bus.angulacao !== 4'sd0) || (bus.busy !== 1'b0) || (obs !== model_vec())) begin
      tests_failed++;
      $display("FAIL reset_mid_T6 got=%b exp=%b", obs, model_vec());
    end
    rst_n = 1'b1;
    bus.cmd_angle = 4'd0;
    bus.cmd_valid = 1'b1;
    #1;
    step();
    bus.cmd_valid = 1'b0;
    tests_run++;
    if ((bus.done !== 1'b1) || (bus.busy !== 1'b0) || (bus.angulacao !== 4'sd0) || (obs !== model_vec())) begin
      tests_failed++;
      $display("FAIL reset_mid_zero_cmd got=%b exp=%b", obs, model_vec());
    end
  endtask

  task automatic test_random();
    int center_left = 0;
    logic [7:0] exp_v;
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (center_left > 0) begin
        center_left--;
        bus.center_req = 1'b1;
      end else begin
        bus.center_req = 1'b0;
        if ($urandom_range(0, 39) == 0) center_left = $urandom_range(1, 20);
      end
      bus.cmd_valid = ($urandom_range(0, 3) == 0);
      bus.cmd_angle = 4'($urandom_range(0, 15));
      step();
      exp_q.push_back(model_vec());
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL random n=%0d got=%b exp=%b", n, obs, exp_v);
      end
      tests_run++;
      if (bus.angulacao === 4'b1000) begin
        tests_failed++;
        $display("FAIL random_range n=%0d got=%b exp=-7..7", n, bus.angulacao);
      end
    end
    bus.cmd_valid  = 1'b0;
    bus.center_req = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_center();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
